apb_rr_arbiter: RTL and testbench

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/apb_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB round-robin arbiter: FSM state encoding
// and default sizing parameters.
package apb_arb_pkg;

    // APB master phases; the encoding is fixed so that checkers can decode it
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the one-hot winner among the
// active requests, searching upward from the requester after ptr.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] winner
);

    int   idx;
    logic found;

    // Walk NREQ positions starting at ptr+1 and keep the first active request
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// APB master shared by NREQ requesters. One transfer at a time is granted
// round-robin, its address/data/direction are captured at the grant edge,
// and the granted requester gets a single-cycle done (with err/rdata) on
// slave completion or on an ACCESS-phase timeout.
//
// Handshake: a requester raises req[i] with its addr/wdata/write valid and
// holds req until it sees done[i]; done[i] is a one-cycle pulse, after which
// the requester drops req on the next edge. Nothing the requester changes
// after the grant edge affects the transfer already in flight.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             err,
    output logic [DW-1:0]    rdata,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [AW-1:0]    paddr,
    output logic [DW-1:0]    pwdata,
    input  logic [DW-1:0]    prdata,
    input  logic             pready,
    input  logic             pslverr,
    output apb_state_e       dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    // Counter value seen during the TIMEOUT-th ACCESS cycle (counter starts at 0)
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    // Pointer reset value makes requester 0 the first to be searched
    localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);

    apb_state_e      state;
    apb_state_e      state_next;
    logic [IW-1:0]   last_granted;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   gnt_idx;
    logic [CW-1:0]   acc_cnt;
    logic [NREQ-1:0] winner;
    logic            complete;
    logic            abort;
    logic            finish;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req    (req),
        .ptr    (last_granted),
        .winner (winner)
    );

    // Binary indices of the arbiter winner and of the current grant
    always_comb begin
        win_idx = '0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) win_idx = IW'(i);
            if (gnt[i])    gnt_idx = IW'(i);
        end
    end

    // Transfer ends on slave ready, or is aborted after TIMEOUT waited cycles
    always_comb begin
        complete = (state == ACCESS) && pready;
        abort    = (state == ACCESS) && !pready && (acc_cnt == CNT_LAST);
        finish   = complete || abort;
    end

    // Next-state logic for the APB phase sequence
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // APB phase controls and the completion response back to the requester
    always_comb begin
        psel    = (state != IDLE);
        penable = (state == ACCESS);
        done    = '0;
        err     = 1'b0;
        rdata   = '0;
        if (finish && !preset) begin
            done  = gnt;
            err   = complete ? pslverr : 1'b1;
            rdata = complete ? prdata : '0;
        end
    end

    assign dbg_state = state;

    // State, grant, capture registers, round-robin pointer and ACCESS counter
    always_ff @(posedge pclk) begin
        if (preset) begin
            state        <= IDLE;
            last_granted <= PTR_RST;
            acc_cnt      <= '0;
            gnt          <= '0;
            pwrite       <= 1'b0;
            paddr        <= '0;
            pwdata       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt     <= winner;
                        paddr   <= req_addr[int'(win_idx)*AW +: AW];
                        pwdata  <= req_wdata[int'(win_idx)*DW +: DW];
                        pwrite  <= req_write[win_idx];
                        acc_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        gnt          <= '0;
                        last_granted <= gnt_idx;
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed and randomized bench for apb_rr_arbiter against a transaction-level
// model: a round-robin pick from the last served requester, a captured
// command, and a response that arrives after a chosen number of wait cycles.
module tb_apb_rr_arbiter;
    import apb_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic               pclk;
    logic               preset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [DW-1:0]      rdata;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic [DW-1:0]      prdata;
    logic               pready;
    logic               pslverr;
    apb_state_e         dbg_state;

    int n_checks = 0;
    int n_fails  = 0;
    int last_g;

    apb_rr_arbiter #(
        .NREQ (NREQ), .AW (AW), .DW (DW), .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .dbg_state (dbg_state)
    );

    // Clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Round-robin rule: first active request after the last served one
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic scramble_cmds();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = $urandom;
            req_wdata[i*DW +: DW] = $urandom;
        end
        req_write = NREQ'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_psel"},    psel,    1'b0);
        check({tag, "_penable"}, penable, 1'b0);
        check({tag, "_gnt"},     gnt,     '0);
        check({tag, "_done"},    done,    '0);
        check({tag, "_err"},     err,     1'b0);
        check({tag, "_rdata"},   rdata,   '0);
    endtask

    task automatic reset_dut();
        preset  = 1'b1;
        pready  = 1'b0;
        pslverr = 1'b0;
        #1;
        check("rst_done_hi", done, '0);
        tick();
        tick();
        check_quiet("rst");
        check("rst_paddr",  paddr,     '0);
        check("rst_pwdata", pwdata,    '0);
        check("rst_pwrite", pwrite,    1'b0);
        check("rst_state",  dbg_state, IDLE);
        preset = 1'b0;
        last_g = NREQ - 1;
    endtask

    // One complete transfer starting in IDLE with req already driven.
    // waits = number of ACCESS cycles with pready low (>= TIMEOUT means abort).
    task automatic run_xfer(input int waits, input bit slverr, input logic [DW-1:0] rd_val);
        int              g;
        int              k;
        bit              fin;
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ew;
        logic            ewr;
        check("idle_psel", psel, 1'b0);
        check("idle_gnt",  gnt,  '0);
        check("idle_done", done, '0);
        g = rr_pick(req, last_g);
        if (g < 0) begin
            check("no_request", req, 1);
            return;
        end
        eg     = '0;
        eg[g]  = 1'b1;
        ea     = req_addr[g*AW +: AW];
        ew     = req_wdata[g*DW +: DW];
        ewr    = req_write[g];
        tick();
        check("setup_state",   dbg_state, SETUP);
        check("setup_gnt",     gnt,       eg);
        check("setup_psel",    psel,      1'b1);
        check("setup_penable", penable,   1'b0);
        check("setup_paddr",   paddr,     ea);
        check("setup_pwdata",  pwdata,    ew);
        check("setup_pwrite",  pwrite,    ewr);
        check("setup_done",    done,      '0);
        // Requester-side command changes after the grant must not leak through
        scramble_cmds();
        tick();
        fin = 1'b0;
        k   = 0;
        while (!fin) begin
            k++;
            pready  = (k > waits);
            pslverr = slverr;
            prdata  = pready ? rd_val : DW'($urandom);
            #1;
            check("acc_penable", penable, 1'b1);
            check("acc_gnt",     gnt,     eg);
            check("acc_paddr",   paddr,   ea);
            check("acc_pwdata",  pwdata,  ew);
            if (pready) begin
                check("cpl_done",  done,  eg);
                check("cpl_err",   err,   slverr);
                check("cpl_rdata", rdata, rd_val);
                fin = 1'b1;
            end else if (k == TIMEOUT) begin
                check("to_done",  done,  eg);
                check("to_err",   err,   1'b1);
                check("to_rdata", rdata, '0);
                fin = 1'b1;
            end else begin
                check("wait_done",  done,  '0);
                check("wait_err",   err,   1'b0);
                check("wait_rdata", rdata, '0);
            end
            tick();
        end
        last_g  = g;
        req[g]  = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        check("post_psel",  psel,      1'b0);
        check("post_state", dbg_state, IDLE);
    endtask

    initial begin
        preset    = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        last_g    = NREQ - 1;

        reset_dut();
        tick();
        check_quiet("idle_noreq");

        // Single write from requester 1, ready on first ACCESS
        req_addr[1*AW +: AW]  = 32'h0000_0040;
        req_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
        req_write[1]          = 1'b1;
        req                   = 4'b0010;
        run_xfer(0, 1'b0, 32'h0);

        // Read from requester 2 with three wait cycles
        req_addr[2*AW +: AW] = 32'h0000_0100;
        req_write[2]         = 1'b0;
        req                  = 4'b0100;
        run_xfer(3, 1'b0, 32'h1234_5678);

        // Contention from a fresh reset: all four, then a 0/3 re-request
        reset_dut();
        scramble_cmds();
        req = 4'b1111;
        for (int n = 0; n < NREQ; n++) run_xfer(n % 3, 1'b0, DW'($urandom));
        req = 4'b1001;
        run_xfer(0, 1'b0, DW'($urandom));
        run_xfer(1, 1'b0, DW'($urandom));

        // Timeout with pready never asserted
        scramble_cmds();
        req = 4'b0100;
        run_xfer(TIMEOUT, 1'b0, 32'h0);

        // Slave error reported with done
        scramble_cmds();
        req = 4'b1000;
        run_xfer(1, 1'b1, 32'hCAFE_0001);

        // Reset pulse in the middle of ACCESS
        scramble_cmds();
        req = 4'b0100;
        tick();
        tick();
        check("mid_state", dbg_state, ACCESS);
        pready = 1'b1;
        preset = 1'b1;
        #1;
        check("mid_rst_done",  done,  '0);
        check("mid_rst_err",   err,   1'b0);
        check("mid_rst_rdata", rdata, '0);
        tick();
        req    = '0;
        pready = 1'b0;
        check_quiet("mid_rst");
        check("mid_rst_paddr",  paddr,     '0);
        check("mid_rst_pwdata", pwdata,    '0);
        check("mid_rst_state",  dbg_state, IDLE);
        preset = 1'b0;
        last_g = NREQ - 1;
        tick();
        check_quiet("mid_rst_idle");
        req = 4'b0101;
        run_xfer(0, 1'b0, DW'($urandom));
        run_xfer(2, 1'b0, DW'($urandom));

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            int w;
            scramble_cmds();
            req = req | NREQ'($urandom_range(1, (1 << NREQ) - 1));
            w   = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 4);
            run_xfer(w, 1'($urandom_range(0, 1)), DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
